// File: rtl/pow_target_check.sv
// Byte-serial "hash < target" check for nonce search; one byte pair per cycle, MSB first.
// Optional POW_EARLY_EXIT_EN: finish on the first differing byte instead of walking all bytes.

module eight_bit_comp (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       equal,
    output logic       a_greater,
    output logic       b_greater
);

    assign equal     = (a == b);
    assign a_greater = (a > b);
    assign b_greater = (a < b);

endmodule

module pow_target_check #(
    parameter int unsigned NUM_BYTES = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] hash_in,
    input  logic [8*NUM_BYTES-1:0] target_in,
    output logic                   busy,
    output logic                   done,
    output logic                   meets_target,
    output logic                   hash_equal
);

    localparam int unsigned W     = 8 * NUM_BYTES;
    localparam int unsigned IDX_W = $clog2(NUM_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       hash_q, hash_d;
    logic [W-1:0]       target_q, target_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               decided_q, decided_d;
    logic               less_q, less_d;
    logic               done_q, done_d;
    logic               meets_q, meets_d;
    logic               equal_q, equal_d;

    logic [7:0]         hash_byte;
    logic [7:0]         target_byte;
    logic               cmp_eq;
    logic               cmp_a_gt;
    logic               cmp_b_gt;
    logic               last_byte;
    logic               exit_cmp;

    assign hash_byte   = hash_q[{idx_q, 3'b000} +: 8];
    assign target_byte = target_q[{idx_q, 3'b000} +: 8];

    eight_bit_comp u_cmp (
        .a         (hash_byte),
        .b         (target_byte),
        .equal     (cmp_eq),
        .a_greater (cmp_a_gt),
        .b_greater (cmp_b_gt)
    );

    assign last_byte = (idx_q == '0);

`ifdef POW_EARLY_EXIT_EN
    assign exit_cmp = last_byte || (!decided_q && !cmp_eq);
`else
    assign exit_cmp = last_byte;
`endif

    always_comb begin
        state_d   = state_q;
        hash_d    = hash_q;
        target_d  = target_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        less_d    = less_q;
        done_d    = 1'b0;
        meets_d   = meets_q;
        equal_d   = equal_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CMP;
                    hash_d    = hash_in;
                    target_d  = target_in;
                    idx_d     = IDX_W'(NUM_BYTES - 1);
                    decided_d = 1'b0;
                    less_d    = 1'b0;
                    meets_d   = 1'b0;
                    equal_d   = 1'b0;
                end
            end

            S_CMP: begin
                // Only the most significant differing byte decides the verdict.
                if (!decided_q && !cmp_eq) begin
                    decided_d = 1'b1;
                    if (cmp_b_gt) begin
                        less_d = 1'b1;
                    end else if (cmp_a_gt) begin
                        less_d = 1'b0;
                    end
                end
                if (exit_cmp) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    meets_d = less_d;
                    equal_d = !decided_d;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hash_q    <= '0;
            target_q  <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            less_q    <= 1'b0;
            done_q    <= 1'b0;
            meets_q   <= 1'b0;
            equal_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hash_q    <= hash_d;
            target_q  <= target_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            less_q    <= less_d;
            done_q    <= done_d;
            meets_q   <= meets_d;
            equal_q   <= equal_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign meets_target = meets_q;
    assign hash_equal   = equal_q;

endmodule
